// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets, FSM encoding and widths.
// GPIO_DATA_WIDTH is also used by the SPI-to-APB bridge so both ends agree.
package gpio_pkg;

  localparam int GPIO_DATA_WIDTH = 8;
  localparam int WAIT_CNT_WIDTH  = 4;

  localparam logic [2:0] GPIO_DIR      = 3'h0;
  localparam logic [2:0] GPIO_OUT      = 3'h1;
  localparam logic [2:0] GPIO_IN       = 3'h2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'h3;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'h4;
  localparam logic [2:0] GPIO_OUT_SET  = 3'h5;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'h6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } gpio_state_e;

  // Offset 7 is the only hole in the low-3-bit map.
  function automatic logic reg_mapped(input logic [2:0] reg_addr);
    return reg_addr != 3'h7;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser plus a delay stage that yields a one-cycle pulse
// for every rising edge of the synchronised inputs.
module gpio_sync_edge #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] sync_out,
  output logic [DATA_WIDTH-1:0] rise
);

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] sync2_d;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= gpio_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign sync_out = sync2;
  assign rise     = sync2 & ~sync2_d;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB completer for one GPIO bank: direction/output/interrupt registers,
// synchronised pad inputs and a registered level interrupt on rising edges.
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = GPIO_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_STATES);

  gpio_state_e               state;
  gpio_state_e               next_state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic [WAIT_CNT_WIDTH-1:0] next_cnt;

  logic [DATA_WIDTH-1:0] dir_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] irq_en;
  logic [DATA_WIDTH-1:0] irq_stat;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] in_rise;

  logic                  access_phase;
  logic [2:0]            reg_addr;
  logic                  unmapped;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] stat_clr;
  logic [DATA_WIDTH-1:0] read_mux;

  gpio_sync_edge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sync_edge (
    .pclk    (pclk),
    .resetn  (resetn),
    .gpio_in (gpio_in),
    .sync_out(in_sync),
    .rise    (in_rise)
  );

  assign access_phase = psel & penable;
  assign reg_addr     = paddr[2:0];
  assign unmapped     = ((paddr >> 3) != '0) || !reg_mapped(reg_addr);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // The first access cycle is seen while still in IDLE so that zero wait
  // states complete immediately; ACCESS only holds the remaining waits.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    case (state)
      IDLE: begin
        if (access_phase && !pready) begin
          next_state = ACCESS;
          next_cnt   = wait_cnt + WAIT_CNT_WIDTH'(1);
        end else begin
          next_cnt   = '0;
        end
      end
      ACCESS: begin
        if (!access_phase || pready) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt   = wait_cnt + WAIT_CNT_WIDTH'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    read_mux = '0;
    case (reg_addr)
      GPIO_DIR:      read_mux = dir_reg;
      GPIO_OUT:      read_mux = out_reg;
      GPIO_IN:       read_mux = in_sync;
      GPIO_IRQ_EN:   read_mux = irq_en;
      GPIO_IRQ_STAT: read_mux = irq_stat;
      default:       read_mux = '0;
    endcase
  end

  always_comb begin
    pready  = access_phase && (wait_cnt == WAIT_LAST);
    pslverr = pready && unmapped;
    prdata  = '0;
    if (pready && !pwrite && !unmapped) begin
      prdata = read_mux;
    end
  end

  assign wr_fire  = pready && pwrite && !unmapped;
  assign stat_clr = (wr_fire && reg_addr == GPIO_IRQ_STAT) ? pwdata : '0;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      dir_reg <= '0;
      out_reg <= '0;
      irq_en  <= '0;
    end else if (wr_fire) begin
      case (reg_addr)
        GPIO_DIR:     dir_reg <= pwdata;
        GPIO_OUT:     out_reg <= pwdata;
        GPIO_IRQ_EN:  irq_en  <= pwdata;
        GPIO_OUT_SET: out_reg <= out_reg | pwdata;
        GPIO_OUT_CLR: out_reg <= out_reg & ~pwdata;
        default:      ;
      endcase
    end
  end

  // Applying the rising-edge set after the clear lets a new edge win a collision.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      irq_stat <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~stat_clr) | in_rise;
      irq_q    <= |(irq_stat & irq_en);
    end
  end

  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank: one instance with no wait states and one
// with three, sharing clock, reset, pads and the non-select bus signals.
module tb_apb_gpio_bank;

  logic       pclk = 1'b0;
  logic       resetn = 1'b0;
  logic       psel0 = 1'b0;
  logic       psel3 = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] gpio_in = '0;

  logic [7:0] prdata0, prdata3, gpio_out0, gpio_out3, gpio_oe0, gpio_oe3;
  logic       pready0, pready3, pslverr0, pslverr3, irq0, irq3;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rd;
  logic       er;
  int         cy;

  always #5 pclk = ~pclk;

  apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .resetn(resetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0)
  );

  apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .resetn(resetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .gpio_in(gpio_in), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3), .irq(irq3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One APB transfer starting at a falling edge; returns at the falling edge after completion.
  task automatic applyStimulus(input bit use3, input bit wr, input logic [7:0] addr,
                               input logic [7:0] wdata, output logic [7:0] rdata,
                               output logic err, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    rdata  = '0;
    err    = 1'b0;
    psel0   = !use3;
    psel3   = use3;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    #1 checkOutput("pready low in setup", use3 ? pready3 : pready0, 0);
    @(negedge pclk);
    penable = 1'b1;
    while (!done && cycles < 32) begin
      #1;
      cycles++;
      if ((use3 ? pready3 : pready0) === 1'b1) begin
        done  = 1'b1;
        rdata = use3 ? prdata3 : prdata0;
        err   = use3 ? pslverr3 : pslverr0;
      end
      @(negedge pclk);
    end
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    if (!done) checkOutput("transfer timeout", 0, 1);
  endtask

  task automatic writeReg(input bit use3, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] r;
    logic       e;
    int         c;
    applyStimulus(use3, 1'b1, addr, data, r, e, c);
  endtask

  task automatic readCheck(input bit use3, input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] r;
    logic       e;
    int         c;
    applyStimulus(use3, 1'b0, addr, 8'h00, r, e, c);
    checkOutput(tag, r, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge pclk);
    resetn = 1'b1;
    @(negedge pclk);
    checkOutput("initial gpio_out", gpio_out0, 8'h00);
    checkOutput("initial gpio_oe", gpio_oe0, 8'h00);
    checkOutput("initial irq", irq0, 0);

    // Zero wait states: basic register access
    applyStimulus(0, 1, 8'h00, 8'hA5, rd, er, cy);
    checkOutput("ws0 write latency", cy, 1);
    checkOutput("gpio_oe after DIR write", gpio_oe0, 8'hA5);
    writeReg(0, 8'h01, 8'h3C);
    checkOutput("gpio_out after OUT write", gpio_out0, 8'h3C);
    applyStimulus(0, 0, 8'h00, 8'h00, rd, er, cy);
    checkOutput("DIR readback", rd, 8'hA5);
    checkOutput("ws0 read latency", cy, 1);
    checkOutput("DIR read no error", er, 0);
    readCheck(0, 8'h01, 8'h3C, "OUT readback");
    writeReg(0, 8'h05, 8'h03);
    checkOutput("OUT_SET result", gpio_out0, 8'h3F);
    writeReg(0, 8'h06, 8'h30);
    checkOutput("OUT_CLR result", gpio_out0, 8'h0F);
    readCheck(0, 8'h01, 8'h0F, "OUT after set/clr");
    readCheck(0, 8'h05, 8'h00, "OUT_SET reads zero");
    applyStimulus(0, 1, 8'h02, 8'hFF, rd, er, cy);
    checkOutput("IN write no error", er, 0);
    readCheck(0, 8'h02, 8'h00, "IN ignores write");
    applyStimulus(0, 0, 8'h07, 8'h00, rd, er, cy);
    checkOutput("ws0 unmapped pslverr", er, 1);
    checkOutput("ws0 unmapped prdata", rd, 8'h00);

    // Three wait states, errors and protocol abort
    applyStimulus(1, 1, 8'h00, 8'h5A, rd, er, cy);
    checkOutput("ws3 write latency", cy, 4);
    checkOutput("ws3 write no error", er, 0);
    checkOutput("ws3 gpio_oe", gpio_oe3, 8'h5A);
    applyStimulus(1, 0, 8'h00, 8'h00, rd, er, cy);
    checkOutput("ws3 DIR readback", rd, 8'h5A);
    checkOutput("ws3 read latency", cy, 4);
    applyStimulus(1, 0, 8'h07, 8'h00, rd, er, cy);
    checkOutput("ws3 read 0x07 pslverr", er, 1);
    checkOutput("ws3 read 0x07 prdata", rd, 8'h00);
    checkOutput("ws3 read 0x07 latency", cy, 4);
    applyStimulus(1, 1, 8'h87, 8'hFF, rd, er, cy);
    checkOutput("ws3 write 0x87 pslverr", er, 1);
    applyStimulus(1, 1, 8'h80, 8'hFF, rd, er, cy);
    checkOutput("ws3 write 0x80 pslverr", er, 1);
    checkOutput("unmapped writes keep gpio_oe", gpio_oe3, 8'h5A);
    checkOutput("unmapped writes keep gpio_out", gpio_out3, 8'h00);
    readCheck(1, 8'h00, 8'h5A, "DIR after unmapped writes");

    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #1 checkOutput("abort: pready still low", pready3, 0);
    @(negedge pclk);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    checkOutput("abort leaves gpio_oe", gpio_oe3, 8'h5A);
    applyStimulus(1, 0, 8'h00, 8'h00, rd, er, cy);
    checkOutput("DIR after abort", rd, 8'h5A);
    checkOutput("latency after abort", cy, 4);

    // Interrupt path latency and W1C
    writeReg(0, 8'h03, 8'h01);
    gpio_in = 8'h01;
    applyStimulus(0, 0, 8'h02, 8'h00, rd, er, cy);
    checkOutput("IN before sync", rd, 8'h00);
    checkOutput("irq 2 cycles after pad", irq0, 0);
    @(negedge pclk);
    checkOutput("irq 3 cycles after pad", irq0, 0);
    @(negedge pclk);
    checkOutput("irq 4 cycles after pad", irq0, 1);
    readCheck(0, 8'h02, 8'h01, "IN after sync");
    readCheck(0, 8'h04, 8'h01, "IRQ_STAT after edge");
    writeReg(0, 8'h04, 8'h01);
    @(negedge pclk);
    checkOutput("irq after W1C", irq0, 0);
    readCheck(0, 8'h04, 8'h00, "IRQ_STAT after W1C");

    // Edge on bit 0 lands on the same edge as a W1C of bits 0 and 1
    gpio_in = 8'h00;
    repeat (4) @(negedge pclk);
    gpio_in = 8'h03;
    repeat (6) @(negedge pclk);
    checkOutput("irq before collision", irq0, 1);
    readCheck(0, 8'h04, 8'h03, "IRQ_STAT ignores IRQ_EN");
    gpio_in = 8'h00;
    repeat (4) @(negedge pclk);
    gpio_in = 8'h01;
    @(negedge pclk);
    writeReg(0, 8'h04, 8'h03);
    checkOutput("irq during collision", irq0, 1);
    @(negedge pclk);
    checkOutput("irq after collision", irq0, 1);
    readCheck(0, 8'h04, 8'h01, "IRQ_STAT set wins");

    // Mid-run reset
    gpio_in = 8'h00;
    repeat (4) @(negedge pclk);
    resetn = 1'b0;
    #1;
    checkOutput("reset gpio_out", gpio_out0, 8'h00);
    checkOutput("reset gpio_oe", gpio_oe0, 8'h00);
    checkOutput("reset irq", irq0, 0);
    checkOutput("reset pready", pready0, 0);
    checkOutput("reset ws3 gpio_oe", gpio_oe3, 8'h00);
    @(negedge pclk);
    resetn = 1'b1;
    @(negedge pclk);
    for (int a = 0; a < 5; a++) begin
      readCheck(0, 8'(a), 8'h00, $sformatf("reg %0d after reset", a));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
